// File: rtl/core_pkg.sv
// Shared constants for the instruction fetch path: AXI encodings and fetch FSM state codes.
package core_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Fetch FSM state encoding (plain constants so legacy tools and checkers can match on them)
    localparam logic [2:0] FETCH_IDLE    = 3'd0;
    localparam logic [2:0] FETCH_AR      = 3'd1;
    localparam logic [2:0] FETCH_AR_KILL = 3'd2;
    localparam logic [2:0] FETCH_R       = 3'd3;
    localparam logic [2:0] FETCH_DRAIN   = 3'd4;

    // Force a byte address onto a 32-bit word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_group_fifo.sv
// Small synchronous FIFO holding assembled fetch groups.
// Push and pop in the same cycle are accepted even when full; clear empties it at the clock edge.
module fetch_group_fifo #(
    parameter int W     = 97,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign do_pop    = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking with explicit wrap (DEPTH may be 1)
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_axi.sv
// AXI3 read-channel instruction fetcher: one INCR burst per fetch group, beats assembled into
// lanes and queued in a small FIFO. Flush kills the in-flight burst while still completing the
// AXI handshakes (AR is never withdrawn, R beats are always drained).
//
// Handshakes: every channel transfers on a cycle where its valid and ready are both high at the
// rising clock edge. A valid, once raised, stays high with stable payload until it is accepted;
// readies may change freely. req_ready, rready and grp_valid are combinational.
module inst_fetch_axi
    import core_pkg::*;
#(
    parameter int ISSUE_W   = 2,
    parameter int BUF_DEPTH = 2,
    parameter int AXI_ID    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    // fetch request from IF_1/IF_2
    input  logic                   req_valid,
    input  logic [31:0]            req_pc,
    output logic                   req_ready,
    input  logic                   flush,
    // fetch group to the IF stage
    output logic                   grp_valid,
    output logic [31:0]            grp_pc,
    output logic [32*ISSUE_W-1:0]  grp_inst,
    output logic                   grp_err,
    input  logic                   grp_ready,
    // AXI AR channel
    output logic                   arvalid,
    output logic [31:0]            araddr,
    output logic [3:0]             arid,
    output logic [3:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic [1:0]             arlock,
    output logic [3:0]             arcache,
    output logic [2:0]             arprot,
    input  logic                   arready,
    // AXI R channel
    input  logic                   rvalid,
    input  logic [31:0]            rdata,
    input  logic [3:0]             rid,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    output logic                   rready,
    // debug view of the fetch FSM
    output logic [2:0]             dbg_state
);

    localparam int GRP_W = 32 + 32 * ISSUE_W + 1;
    // Counter must reach ISSUE_W so that surplus beats can be recognised and dropped
    localparam int CNT_W = $clog2(ISSUE_W + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ISSUE_W - 1);
    localparam logic [CNT_W-1:0] OVER_BEAT = CNT_W'(ISSUE_W);

    logic [2:0]             state;
    logic [31:0]            pc_q;
    logic [CNT_W-1:0]       beat_cnt;
    logic [32*ISSUE_W-1:0]  lanes_q;
    logic [32*ISSUE_W-1:0]  lanes_nxt;
    logic                   err_q;
    logic                   err_nxt;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [GRP_W-1:0]       fifo_head;
    logic                   unused_ok;

    // Fixed AXI attributes: single ID, full-word INCR bursts of ISSUE_W beats
    assign arid    = 4'(AXI_ID);
    assign arlen   = 4'(ISSUE_W - 1);
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    // rid is ignored (only one ID outstanding); low PC bits are forced to zero on araddr
    assign unused_ok = ^{rid, req_pc[1:0]};

    assign dbg_state = state;
    assign req_ready = (state == FETCH_IDLE) & ~flush & ~fifo_full;
    assign rready    = (state == FETCH_R) | (state == FETCH_DRAIN);

    // A flush masks the head so the consumer cannot pop something that is being cleared
    assign grp_valid = ~fifo_empty & ~flush;
    assign fifo_pop  = grp_valid & grp_ready;
    assign fifo_push = (state == FETCH_R) & rvalid & rlast & ~flush;

    assign {grp_pc, grp_inst, grp_err} = fifo_head;

    // Merge the current beat into the lane image and accumulate the error flag
    always_comb begin
        lanes_nxt = lanes_q;
        err_nxt   = err_q;
        if ((state == FETCH_R) && rvalid) begin
            for (int i = 0; i < ISSUE_W; i++) begin
                if (beat_cnt == CNT_W'(i)) begin
                    lanes_nxt[i*32 +: 32] = rdata;
                end
            end
            if (rresp != AXI_RESP_OKAY) begin
                err_nxt = 1'b1;
            end
            // rlast on the wrong beat, or the final lane filled without rlast
            if (rlast && (beat_cnt != LAST_BEAT)) begin
                err_nxt = 1'b1;
            end
            if (!rlast && (beat_cnt == LAST_BEAT)) begin
                err_nxt = 1'b1;
            end
        end
    end

    // Fetch FSM: request accept, AR handshake, beat collection and flush recovery
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH_IDLE;
            arvalid  <= 1'b0;
            araddr   <= '0;
            pc_q     <= '0;
            beat_cnt <= '0;
            lanes_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (req_valid && req_ready) begin
                        araddr   <= word_align(req_pc);
                        pc_q     <= word_align(req_pc);
                        arvalid  <= 1'b1;
                        beat_cnt <= '0;
                        lanes_q  <= '0;
                        err_q    <= 1'b0;
                        state    <= FETCH_AR;
                    end
                end
                FETCH_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= flush ? FETCH_DRAIN : FETCH_R;
                    end else if (flush) begin
                        state <= FETCH_AR_KILL;
                    end
                end
                FETCH_AR_KILL: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= FETCH_DRAIN;
                    end
                end
                FETCH_R: begin
                    if (flush) begin
                        state <= (rvalid && rlast) ? FETCH_IDLE : FETCH_DRAIN;
                    end else if (rvalid) begin
                        lanes_q <= lanes_nxt;
                        err_q   <= err_nxt;
                        if (beat_cnt != OVER_BEAT) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                        if (rlast) begin
                            state <= FETCH_IDLE;
                        end
                    end
                end
                FETCH_DRAIN: begin
                    if (rvalid && rlast) begin
                        state <= FETCH_IDLE;
                    end
                end
                default: begin
                    state <= FETCH_IDLE;
                end
            endcase
        end
    end

    fetch_group_fifo #(
        .W     (GRP_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (fifo_push),
        .push_data ({pc_q, lanes_nxt, err_nxt}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
